// File: rtl/ripple_adder.sv
// ripple_adder: registered WIDTH-bit ripple-carry adder with valid handshake.
//   clk       - single clock, rising-edge active
//   rst_n     - asynchronous active-low reset
//   in_valid  - a, b and cin are captured on this cycle's rising edge
//   a, b      - unsigned WIDTH-bit addends
//   cin       - carry into bit 0
//   c         - registered carry-out of the MSB cell
//   s         - registered WIDTH-bit sum
//   out_valid - one-cycle pulse per captured operation, one cycle after capture
//   ovf       - registered two's-complement overflow flag
module ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             c,
  output logic [WIDTH-1:0] s,
  output logic             out_valid,
  output logic             ovf
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_comb;
  logic             c_comb;
  logic             ovf_comb;

  // Explicit chain of one-bit full-adder cells, bit 0 first.
  always_comb begin
    carry    = '0;
    s_comb   = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s_comb[i]  = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign c_comb   = carry[WIDTH];
  // Signed overflow: carry into the MSB cell differs from the carry out of it.
  assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s   <= s_comb;
        c   <= c_comb;
        ovf <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_ripple_adder.sv
// tb_ripple_adder: directed, table-driven bench for ripple_adder (WIDTH=4).
module tb_ripple_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       c;
  logic [3:0] s;
  logic       out_valid;
  logic       ovf;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       c;
    logic       ovf;
  } vec_t;

  vec_t vecs[20];

  ripple_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .c         (c),
    .s         (s),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic v, input logic [3:0] aa, input logic [3:0] bb, input logic ci);
    @(negedge clk);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] e;
    logic       e_ovf;

    // Sweep a=i, b=(i+1) mod 16, cin=0: expected results computed by hand.
    vecs[0]  = '{4'd0,  4'd1,  1'b0, 4'd1,  1'b0, 1'b0};
    vecs[1]  = '{4'd1,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0};
    vecs[2]  = '{4'd2,  4'd3,  1'b0, 4'd5,  1'b0, 1'b0};
    vecs[3]  = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0, 1'b0};
    vecs[4]  = '{4'd4,  4'd5,  1'b0, 4'd9,  1'b0, 1'b1};
    vecs[5]  = '{4'd5,  4'd6,  1'b0, 4'd11, 1'b0, 1'b1};
    vecs[6]  = '{4'd6,  4'd7,  1'b0, 4'd13, 1'b0, 1'b1};
    vecs[7]  = '{4'd7,  4'd8,  1'b0, 4'd15, 1'b0, 1'b0};
    vecs[8]  = '{4'd8,  4'd9,  1'b0, 4'd1,  1'b1, 1'b1};
    vecs[9]  = '{4'd9,  4'd10, 1'b0, 4'd3,  1'b1, 1'b1};
    vecs[10] = '{4'd10, 4'd11, 1'b0, 4'd5,  1'b1, 1'b1};
    vecs[11] = '{4'd11, 4'd12, 1'b0, 4'd7,  1'b1, 1'b1};
    vecs[12] = '{4'd12, 4'd13, 1'b0, 4'd9,  1'b1, 1'b0};
    vecs[13] = '{4'd13, 4'd14, 1'b0, 4'd11, 1'b1, 1'b0};
    vecs[14] = '{4'd14, 4'd15, 1'b0, 4'd13, 1'b1, 1'b0};
    vecs[15] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
    // Carry-in full ripple and signed overflow cases.
    vecs[16] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
    vecs[17] = '{4'd7,  4'd0,  1'b1, 4'd8,  1'b0, 1'b1};
    vecs[18] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    vecs[19] = '{4'd5,  4'd2,  1'b0, 4'd7,  1'b0, 1'b0};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_s",         32'(s),         32'd0);
    chk("reset_c",         32'(c),         32'd0);
    chk("reset_ovf",       32'(ovf),       32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);

    // in_valid ignored while reset is held.
    drive(1'b1, 4'd3, 4'd3, 1'b0);
    chk("reset_ignores_valid_ov", 32'(out_valid), 32'd0);
    chk("reset_ignores_valid_s",  32'(s),         32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Back-to-back table: one result per cycle, one cycle latency.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("vec%0d_s",   i), 32'(s),         32'(vecs[i].s));
      chk($sformatf("vec%0d_c",   i), 32'(c),         32'(vecs[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf),       32'(vecs[i].ovf));
      chk($sformatf("vec%0d_ov",  i), 32'(out_valid), 32'd1);
    end

    // Hold and valid pulse: 3+4, then idle with a changed.
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    chk("idle_ov", 32'(out_valid), 32'd0);
    drive(1'b1, 4'd3, 4'd4, 1'b0);
    chk("hold_cap_s",  32'(s),         32'd7);
    chk("hold_cap_ov", 32'(out_valid), 32'd1);
    // Input change between edges must not reach the outputs.
    #2 a = 4'd9;
    #1;
    chk("between_edges_s", 32'(s), 32'd7);
    drive(1'b0, 4'd9, 4'd4, 1'b0);
    chk("hold_s",   32'(s),         32'd7);
    chk("hold_c",   32'(c),         32'd0);
    chk("hold_ov",  32'(out_valid), 32'd0);
    drive(1'b0, 4'd9, 4'd9, 1'b1);
    chk("hold2_s",  32'(s),         32'd7);

    // Async reset between edges while s=7; pending op is discarded.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd8;
    b        = 4'd8;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_s",   32'(s),         32'd0);
    chk("async_rst_c",   32'(c),         32'd0);
    chk("async_rst_ovf", 32'(ovf),       32'd0);
    chk("async_rst_ov",  32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("async_rst_discard_ov", 32'(out_valid), 32'd0);
    chk("async_rst_discard_s",  32'(s),         32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    chk("post_rst_s",  32'(s),         32'd5);
    chk("post_rst_ov", 32'(out_valid), 32'd1);

    // Exhaustive 512 cases against an arithmetic reference.
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          drive(1'b1, 4'(ai), 4'(bi), 1'(ci));
          e     = 5'(ai + bi + ci);
          e_ovf = (4'(ai) >> 3) == (4'(bi) >> 3) && e[3] != 1'((ai >> 3) & 1);
          chk($sformatf("exh_%0d_%0d_%0d_sum", ai, bi, ci), 32'({c, s}), 32'(e));
          chk($sformatf("exh_%0d_%0d_%0d_ovf", ai, bi, ci), 32'(ovf),    32'(e_ovf));
        end

    @(negedge clk);
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
